out_seq_ctrl: RTL and testbench

OUT_SEQ_CTRL -- requirements
Module: out_seq_ctrl

---
 rtl/out_seq_ctrl.sv | 112 +++++++++++
 tb/tb_out_seq_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/out_seq_ctrl.sv
// Output sequencer: on each kernel-finished pulse, sweeps every channel at the current window.
// Each beat's address, first-beat flag and last-beat flag travel down a stallable pipeline to the outputs.
module out_seq_ctrl #(
  parameter int OSW  = 10,
  parameter int ODW  = 4,
  parameter int AW   = 12,
  parameter int PIPE = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           acc_mode,
  input  logic           s_init,
  input  logic           k_fin,
  input  logic           stall,
  input  logic [ODW-1:0] od,
  input  logic [OSW-1:0] os,
  output logic           out_busy,
  output logic           outr,
  output logic           accr,
  output logic [AW-1:0]  oa,
  output logic           update,
  output logic           done,
  output logic           err
);

  localparam int PW = ODW + OSW + 1;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t          state;
  logic [ODW-1:0]  ct;
  logic [OSW-1:0]  wi;
  logic            pending;

  logic [PIPE-1:0] pv;
  logic [PIPE-1:0] pf;
  logic [PIPE-1:0] pl;
  logic [AW-1:0]   pa [PIPE];

  logic            issue;
  logic            ch_wrap;
  logic            win_wrap;
  logic [PW-1:0]   prod;

  always_comb begin
    issue    = (state == SWEEP) && !stall;
    ch_wrap  = (ct == od);
    win_wrap = (wi == os - OSW'(1));
    prod     = PW'(ct) * PW'(os) + PW'(wi);
  end

  // A k_fin landing on the channel wrap chains a new sweep with no bubble;
  // s_init is applied last so it overrides any window increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ct      <= '0;
      wi      <= '0;
      pending <= 1'b0;
      err     <= 1'b0;
      pv      <= '0;
      pf      <= '0;
      pl      <= '0;
      for (int i = 0; i < PIPE; i++) pa[i] <= '0;
    end else begin
      if (issue) begin
        if (ch_wrap) begin
          ct <= '0;
          wi <= win_wrap ? '0 : wi + OSW'(1);
          if (pending)     pending <= 1'b0;
          else if (!k_fin) state   <= IDLE;
        end else begin
          ct <= ct + ODW'(1);
        end
      end
      if (k_fin) begin
        if (state == IDLE) begin
          state <= SWEEP;
          ct    <= '0;
        end else if (pending) begin
          err <= 1'b1;
        end else if (!(issue && ch_wrap)) begin
          pending <= 1'b1;
        end
      end
      if (s_init) begin
        wi <= '0;
        if (state == SWEEP) err <= 1'b1;
      end
      if (!stall) begin
        for (int i = 1; i < PIPE; i++) begin
          pv[i] <= pv[i-1];
          pf[i] <= pf[i-1];
          pl[i] <= pl[i-1];
          pa[i] <= pa[i-1];
        end
        pv[0] <= issue;
        pf[0] <= issue && (ct == '0);
        pl[0] <= issue && ch_wrap && win_wrap;
        pa[0] <= issue ? AW'(prod) : '0;
      end
    end
  end

  assign out_busy = pending;
  assign outr     = pv[PIPE-1];
  assign oa       = pa[PIPE-1];
  assign update   = pf[PIPE-1];
  assign done     = pv[PIPE-1] & pl[PIPE-1];
  assign accr     = pv[PIPE-2] & acc_mode;

endmodule

// File: tb/tb_out_seq_ctrl.sv
// Bench for out_seq_ctrl: directed timing scenarios plus random traffic.
// All traffic is checked against a drain/beat reference model.
module tb_out_seq_ctrl;

  localparam int OSW  = 10;
  localparam int ODW  = 4;
  localparam int AW   = 12;
  localparam int PIPE = 3;

  logic           clk;
  logic           rst;
  logic           acc_mode;
  logic           s_init;
  logic           k_fin;
  logic           stall;
  logic [ODW-1:0] od;
  logic [OSW-1:0] os;
  logic           out_busy;
  logic           outr;
  logic           accr;
  logic [AW-1:0]  oa;
  logic           update;
  logic           done;
  logic           err;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] a;
    logic          f;
    logic          l;
  } beat_t;

  // Reference model: beats left in the current drain, a queued-drain flag,
  // window index, sticky error and a PIPE-deep delay line of issued beats.
  int    m_rem;
  bit    m_pend;
  int    m_wi;
  bit    m_err;
  beat_t line [PIPE];

  out_seq_ctrl #(.OSW(OSW), .ODW(ODW), .AW(AW), .PIPE(PIPE)) dut (
    .clk(clk), .rst(rst), .acc_mode(acc_mode), .s_init(s_init), .k_fin(k_fin),
    .stall(stall), .od(od), .os(os), .out_busy(out_busy), .outr(outr), .accr(accr),
    .oa(oa), .update(update), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input bit kf, input bit si, input bit st, input bit r);
    int    rem0;
    int    c;
    bit    iss;
    beat_t b;
    if (r) begin
      m_rem = 0; m_pend = 0; m_wi = 0; m_err = 0;
      for (int i = 0; i < PIPE; i++) line[i] = '0;
      return;
    end
    rem0 = m_rem;
    iss  = 0;
    b    = '0;
    if (m_rem > 0 && !st) begin
      c   = int'(od) + 1 - m_rem;
      b.v = 1'b1;
      b.a = AW'((c * int'(os) + m_wi) % (1 << AW));
      b.f = (c == 0);
      b.l = (c == int'(od)) && (m_wi == int'(os) - 1);
      m_rem--;
      iss = 1;
      if (c == int'(od)) m_wi = (m_wi + 1) % int'(os);
    end
    if (iss && m_rem == 0 && m_pend) begin
      m_pend = 0;
      m_rem  = int'(od) + 1;
      if (kf) m_err = 1;
    end else if (kf) begin
      if (rem0 == 0)                m_rem  = int'(od) + 1;
      else if (m_pend)              m_err  = 1;
      else if (iss && m_rem == 0)   m_rem  = int'(od) + 1;
      else                          m_pend = 1;
    end
    if (si) begin
      m_wi = 0;
      if (rem0 > 0) m_err = 1;
    end
    if (!st) begin
      for (int i = PIPE - 1; i > 0; i--) line[i] = line[i-1];
      line[0] = b;
    end
  endtask

  task automatic check_output();
    chk("outr",     32'(outr),     32'(line[PIPE-1].v));
    chk("oa",       32'(oa),       32'(line[PIPE-1].a));
    chk("update",   32'(update),   32'(line[PIPE-1].f));
    chk("done",     32'(done),     32'(line[PIPE-1].v & line[PIPE-1].l));
    chk("accr",     32'(accr),     32'(line[PIPE-2].v & acc_mode));
    chk("out_busy", 32'(out_busy), 32'(m_pend));
    chk("err",      32'(err),      32'(m_err));
  endtask

  task automatic apply_stimulus(input bit kf, input bit si, input bit st, input bit r);
    k_fin  = kf;
    s_init = si;
    stall  = st;
    rst    = r;
    @(posedge clk);
    model_edge(kf, si, st, r);
    #1;
    check_output();
    k_fin  = 1'b0;
    s_init = 1'b0;
    stall  = 1'b0;
    rst    = 1'b0;
  endtask

  task automatic do_reset();
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  int exp_oa [8] = '{0, 2, 4, 6, 1, 3, 5, 7};
  int vc;

  initial begin
    rst = 1'b1; k_fin = 1'b0; s_init = 1'b0; stall = 1'b0;
    acc_mode = 1'b0; od = 4'd3; os = 10'd2;
    do_reset();
    chk("rst_outr", 32'(outr), 32'd0);
    chk("rst_err",  32'(err),  32'd0);
    chk("rst_oa",   32'(oa),   32'd0);

    // Single sweep, with and without accumulate.
    for (int a = 0; a < 2; a++) begin
      acc_mode = a[0];
      do_reset();
      for (int c = 0; c < 10; c++) begin
        apply_stimulus(c == 0, 1'b0, 1'b0, 1'b0);
        vc = c + 1;
        chk("s1_outr",   32'(outr),   32'(vc >= 4 && vc <= 7));
        chk("s1_update", 32'(update), 32'(vc == 4));
        chk("s1_accr",   32'(accr),   32'(a == 1 && vc >= 3 && vc <= 6));
        if (vc >= 4 && vc <= 7) chk("s1_oa", 32'(oa), 32'(exp_oa[vc-4]));
      end
    end

    // Chained second drain.
    acc_mode = 1'b0;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      apply_stimulus(c == 0 || c == 2, 1'b0, 1'b0, 1'b0);
      vc = c + 1;
      chk("s2_busy",   32'(out_busy), 32'(vc >= 3 && vc <= 4));
      chk("s2_outr",   32'(outr),     32'(vc >= 4 && vc <= 11));
      chk("s2_update", 32'(update),   32'(vc == 4 || vc == 8));
      chk("s2_done",   32'(done),     32'(vc == 11));
      if (vc >= 4 && vc <= 11) chk("s2_oa", 32'(oa), 32'(exp_oa[vc-4]));
    end

    // Stall freezes the pipeline.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      apply_stimulus(c == 0, 1'b0, c == 5 || c == 6, 1'b0);
      vc = c + 1;
      chk("s3_outr", 32'(outr), 32'(vc >= 4 && vc <= 9));
      if (vc >= 5 && vc <= 7) chk("s3_oa_frozen", 32'(oa), 32'd2);
      if (vc == 9) chk("s3_oa_last", 32'(oa), 32'd6);
    end

    // Third k_fin while busy is an error and is dropped.
    do_reset();
    for (int c = 0; c < 15; c++) begin
      apply_stimulus(c == 0 || c == 2 || c == 3, 1'b0, 1'b0, 1'b0);
      vc = c + 1;
      chk("s4_err",  32'(err),  32'(vc >= 4));
      chk("s4_outr", 32'(outr), 32'(vc >= 4 && vc <= 11));
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    chk("s4_err_clr", 32'(err), 32'd0);

    // Reset mid-sweep aborts everything.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      apply_stimulus(c == 0, 1'b0, 1'b0, c == 5);
      vc = c + 1;
      if (vc >= 6) begin
        chk("s5_outr", 32'(outr), 32'd0);
        chk("s5_oa",   32'(oa),   32'd0);
      end
    end

    // Random traffic against the model; config only changes across resets.
    for (int seg = 0; seg < 7; seg++) begin
      do_reset();
      if (seg == 6) begin
        od = 4'd15;
        os = 10'd1000;
      end else begin
        od = ODW'($urandom_range(0, 5));
        os = OSW'($urandom_range(1, 6));
      end
      acc_mode = 1'($urandom_range(0, 1));
      for (int c = 0; c < 200; c++) begin
        apply_stimulus(($urandom % 8) == 0, ($urandom % 40) == 0,
                       ($urandom % 4) == 0, ($urandom % 300) == 0);
      end
      for (int c = 0; c < 60; c++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
